// File: rtl/clkmon_ctrl_if.sv
// Control/status bundle between clkmon_ctrl and the PLL, clkmon and clock consumers.
// loss_cnt is present only when CLKMON_CTRL_LOSS_CNT_EN is defined.
interface clkmon_ctrl_if #(
  parameter int unsigned MAX_RETRY = 3
);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic               enable;
  logic               pll_locked;
  logic               tst_ok;
  logic               pll_rst;
  logic               mon_rst_n;
  logic               clk_good;
  logic               fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [2:0]         state;
`ifdef CLKMON_CTRL_LOSS_CNT_EN
  logic [15:0]        loss_cnt;
`endif

  // Supervisor side
  modport master (
    input  enable, pll_locked, tst_ok,
    output pll_rst, mon_rst_n, clk_good, fail, retry_cnt, state
`ifdef CLKMON_CTRL_LOSS_CNT_EN
    , output loss_cnt
`endif
  );

  // Board / consumer side
  modport slave (
    output enable, pll_locked, tst_ok,
    input  pll_rst, mon_rst_n, clk_good, fail, retry_cnt, state
`ifdef CLKMON_CTRL_LOSS_CNT_EN
    , input loss_cnt
`endif
  );
endinterface

// File: rtl/clkmon_ctrl.sv
// PLL + clkmon bring-up supervisor with bounded retry; declares clk_good once verified.
// Optional RUN-loss event counter enabled by CLKMON_CTRL_LOSS_CNT_EN.
module clkmon_ctrl #(
  parameter int unsigned CLK_MHZ   = 100,
  parameter int unsigned RST_US    = 10,
  parameter int unsigned LOCK_US   = 1000,
  parameter int unsigned SETTLE_US = 100,
  parameter int unsigned OK_US     = 1000,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic          clk,
  input  logic          rst,
  clkmon_ctrl_if.master bus
);
  localparam int unsigned RETRY_W    = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned RST_CYC    = CLK_MHZ * RST_US;
  localparam int unsigned LOCK_CYC   = CLK_MHZ * LOCK_US;
  localparam int unsigned SETTLE_CYC = CLK_MHZ * SETTLE_US;
  localparam int unsigned OK_CYC     = CLK_MHZ * OK_US;
  localparam int unsigned MAX_A      = (RST_CYC > LOCK_CYC) ? RST_CYC : LOCK_CYC;
  localparam int unsigned MAX_B      = (SETTLE_CYC > OK_CYC) ? SETTLE_CYC : OK_CYC;
  localparam int unsigned TMR_MAX    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLL_RST   = 3'd1,
    WAIT_LOCK = 3'd2,
    SETTLE    = 3'd3,
    WAIT_OK   = 3'd4,
    RUN       = 3'd5,
    FAILED    = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [1:0]         sync_q;
  logic               locked_s;
  logic               do_retry;
  logic               pll_rst_q, pll_rst_d;
  logic               mon_rst_n_q, mon_rst_n_d;
  logic               clk_good_q, clk_good_d;
  logic               fail_q, fail_d;

  // Timer holds N-1 on entry so a state with budget N lasts N cycles before expiry acts.
  function automatic logic [TMR_W-1:0] tmr_load(input state_e s);
    unique case (s)
      PLL_RST:   tmr_load = TMR_W'(RST_CYC - 1);
      WAIT_LOCK: tmr_load = TMR_W'(LOCK_CYC - 1);
      SETTLE:    tmr_load = TMR_W'(SETTLE_CYC - 1);
      WAIT_OK:   tmr_load = TMR_W'(OK_CYC - 1);
      default:   tmr_load = '0;
    endcase
  endfunction

  assign locked_s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      tmr_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      mon_rst_n_q <= 1'b0;
      clk_good_q  <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], bus.pll_locked};
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      mon_rst_n_q <= mon_rst_n_d;
      clk_good_q  <= clk_good_d;
      fail_q      <= fail_d;
    end
  end

  // Success conditions are tested before timer expiry so a coincident expiry still succeeds.
  always_comb begin
    state_d  = state_q;
    retry_d  = retry_q;
    do_retry = 1'b0;
    unique case (state_q)
      IDLE:      if (bus.enable) state_d = PLL_RST;
      PLL_RST:   if (tmr_q == '0) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (locked_s)          state_d  = SETTLE;
        else if (tmr_q == '0)  do_retry = 1'b1;
      end
      SETTLE: begin
        if (!locked_s)         do_retry = 1'b1;
        else if (tmr_q == '0)  state_d  = WAIT_OK;
      end
      WAIT_OK: begin
        if (bus.tst_ok) begin
          state_d = RUN;
          retry_d = '0;
        end else if (tmr_q == '0) begin
          do_retry = 1'b1;
        end
      end
      RUN:       if (!bus.tst_ok || !locked_s) do_retry = 1'b1;
      FAILED:    state_d = FAILED;
      default:   state_d = IDLE;
    endcase

    if (do_retry) begin
      if (retry_q == RETRY_W'(MAX_RETRY)) begin
        state_d = FAILED;
      end else begin
        state_d = PLL_RST;
        retry_d = retry_q + RETRY_W'(1);
      end
    end

    if (!bus.enable) begin
      state_d = IDLE;
      retry_d = '0;
    end

    if (state_d != state_q)  tmr_d = tmr_load(state_d);
    else if (tmr_q != '0)    tmr_d = tmr_q - TMR_W'(1);
    else                     tmr_d = tmr_q;

    pll_rst_d   = (state_d == IDLE) || (state_d == PLL_RST) || (state_d == FAILED);
    mon_rst_n_d = (state_d == WAIT_OK) || (state_d == RUN);
    clk_good_d  = (state_d == RUN);
    fail_d      = (state_d == FAILED);
  end

`ifdef CLKMON_CTRL_LOSS_CNT_EN
  logic [15:0] loss_q;

  // Counts genuine RUN losses only; a disable out of RUN is not a loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      loss_q <= '0;
    end else if ((state_q == RUN) && do_retry && bus.enable && (loss_q != 16'hFFFF)) begin
      loss_q <= loss_q + 16'd1;
    end
  end

  assign bus.loss_cnt = loss_q;
`endif

  assign bus.state     = state_q;
  assign bus.retry_cnt = retry_q;
  assign bus.pll_rst   = pll_rst_q;
  assign bus.mon_rst_n = mon_rst_n_q;
  assign bus.clk_good  = clk_good_q;
  assign bus.fail      = fail_q;
endmodule

// File: doc/clkmon_ctrl.md
# clkmon_ctrl

Clock-source supervisor that sequences a PLL and its `clkmon` frequency monitor. It resets the PLL, waits for lock and a settle interval, then releases the monitor and waits for `tst_ok`. It declares the clock good and retries the whole sequence on failure, up to a bounded count. It sits in the reference-clock domain, between the board-level PLL and the logic that consumes `clk_good`.

## Interface
- `CLK_MHZ`, 100, reference clock frequency; all `*_US` values are converted to cycles as `CLK_MHZ*US`.
- `RST_US`, 10, PLL reset pulse width.
- `LOCK_US`, 1000, timeout for PLL lock.
- `SETTLE_US`, 100, time lock must be held continuously before the monitor is released.
- `OK_US`, 1000, timeout for `tst_ok` after monitor release.
- `MAX_RETRY`, 3, failed attempts allowed before FAILED; `retry_cnt` width is `$clog2(MAX_RETRY+1)`.

- `clk` in 1: reference clock; the same clock that drives `clkmon`.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: start/keep supervising; 0 forces IDLE.
- `pll_locked` in 1: asynchronous PLL lock; synchronized internally by 2 flops.
- `tst_ok` in 1: `clkmon` status, already in the `clk` domain.
- `pll_rst` out 1: PLL reset, active-high.
- `mon_rst_n` out 1: `clkmon` reset, active-low.
- `clk_good` out 1: monitored clock verified.
- `fail` out 1: retries exhausted.
- `retry_cnt` out W: failed attempts since the last RUN or IDLE.
- `state` out 3: IDLE=0, PLL_RST=1, WAIT_LOCK=2, SETTLE=3, WAIT_OK=4, RUN=5, FAILED=6.

## Operation
- **Reset values:** state=IDLE, `pll_rst`=1, `mon_rst_n`=0, `clk_good`=0, `fail`=0, `retry_cnt`=0, timer=0, synchronizer=0.
- **Timer:** a single down-counter, reloaded on every state entry; "expires" means it has reached 0.
- **IDLE:** `pll_rst`=1, `mon_rst_n`=0. When `enable`=1, go to PLL_RST.
- **PLL_RST:** `pll_rst`=1 for RST cycles, then go to WAIT_LOCK.
- **WAIT_LOCK:** `pll_rst`=0. When `locked_s`=1, go to SETTLE. When the LOCK timer expires, run RETRY.
- **SETTLE:** if `locked_s`=0 in any cycle, run RETRY. If the SETTLE timer expires, go to WAIT_OK.
- **WAIT_OK:** `mon_rst_n`=1. When `tst_ok`=1, go to RUN and clear `retry_cnt`. When the OK timer expires, run RETRY.
- **RUN:** `clk_good`=1, `mon_rst_n`=1. If `tst_ok`=0 or `locked_s`=0, run RETRY.
- **RETRY** (a transition, not a state):
  - If `retry_cnt`==MAX_RETRY, go to FAILED.
  - Otherwise increment `retry_cnt` and go to PLL_RST.
- **FAILED:** `fail`=1, `pll_rst`=1, `mon_rst_n`=0. Hold until `enable`=0.
- **`enable`=0:** from any state, go to IDLE on the next edge and clear `retry_cnt` and `fail`. This has priority over every other transition.
- **Simultaneous events:** a timer expiry coinciding with a success condition counts as success.
- **In-cycle ordering:** the `rst` > `enable`=0 > state logic.

## Timing
- All outputs are registered, decoded from the next state, and change on the same edge as `state`.
- `pll_locked` to `locked_s` latency is 2 cycles.
- RUN exit: `clk_good` falls on the first edge after the cycle in which `tst_ok`=0 is sampled.
- `rst` asserted mid-sequence: outputs return to their reset values on the next edge, and the timer is discarded.
- Minimum enable-to-`clk_good` latency is 1+RST+1+SETTLE+1 cycles plus the lock/ok response times and the synchronizer.

## Configuration
- `CLKMON_CTRL_LOSS_CNT_EN`:
  - **Defined:** adds output `loss_cnt` [15:0]. It increments, saturating at 0xFFFF, on each RUN→RETRY exit. It is cleared only by `rst`.
  - **Undefined:** the port and counter are absent, and all other behaviour is identical.

## Test plan
All cases use CLK_MHZ=100, RST_US=1, LOCK_US=5, SETTLE_US=2, OK_US=5, MAX_RETRY=3.

- **Nominal:** `enable`=1, `pll_locked` rises 50 cycles after `pll_rst` falls, `tst_ok` rises 30 cycles after `mon_rst_n` rises → `pll_rst` is high for exactly 100 cycles, `clk_good`=1, `retry_cnt`=0.
- **Lock timeout:** `pll_locked` held 0 → 4 attempts, each with a 500-cycle WAIT_LOCK; `retry_cnt` counts 1,2,3; then `fail`=1, state=6, `pll_rst`=1.
- **Lock drop in SETTLE:** `pll_locked` falls 100 cycles into SETTLE → `retry_cnt`=1 and a new 100-cycle `pll_rst` pulse, with `mon_rst_n` never released.
- **Loss in RUN:** after RUN, drop `tst_ok` → `clk_good`=0 on the next edge, state=1, `retry_cnt`=1; with the macro defined, `loss_cnt`=1.
- **Disable mid-sequence:** `enable`=0 during WAIT_OK, or during FAILED → IDLE next edge, `fail`=0, `retry_cnt`=0; re-enable restarts from PLL_RST.
- **Reset mid-RUN:** `rst` pulsed 1 cycle → all outputs at reset values on the next edge; with `enable` held at 1, the sequence restarts.
